// File: rtl/ex.sv
// ex: execute stage of the five-stage pipeline.
// Turns the decoded operation and operands from ID/EX into the write-back
// destination, result and HI/LO update for EX/MEM. ALU, shift, compare,
// multiply and link results are combinational. DIV/DIVU runs on an iterative
// radix-2 restoring divider and holds the upstream pipeline via stallreq.
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   aluop_i, alusel_i   operation code and result class
//   reg1_i, reg2_i      operands (shifts: reg1_i[4:0] amount, reg2_i value)
//   wd_i, wreg_i        destination address and write enable
//   link_address_i      return address for link instructions
//   hi_i, lo_i          current (forwarded) HI/LO
//   stall               pipeline stall vector, bit 3 is this stage
//   wd_o, wreg_o        destination passthrough; wreg_o dropped on overflow
//   wdata_o             GPR write-back data
//   whilo_o, hi_o, lo_o HI/LO write enable and new values
//   stallreq            request to stall IF through EX while dividing
module ex (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [2:0]  alusel_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] link_address_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic [5:0]  stall,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        stallreq
);

    localparam int unsigned RegBus  = 32;
    localparam int unsigned WorkW   = 2 * RegBus + 1;
    localparam int unsigned CntW    = 6;

    // Result classes
    localparam logic [2:0] EXE_RES_LOGIC       = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT       = 3'b010;
    localparam logic [2:0] EXE_RES_MOVE        = 3'b011;
    localparam logic [2:0] EXE_RES_ARITHMETIC  = 3'b100;
    localparam logic [2:0] EXE_RES_MUL         = 3'b101;
    localparam logic [2:0] EXE_RES_JUMP_BRANCH = 3'b110;

    // Operation codes
    localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP    = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP   = 8'b0010_0110;
    localparam logic [7:0] EXE_NOR_OP   = 8'b0010_0111;
    localparam logic [7:0] EXE_ANDI_OP  = 8'b0101_1001;
    localparam logic [7:0] EXE_ORI_OP   = 8'b0101_1010;
    localparam logic [7:0] EXE_XORI_OP  = 8'b0101_1011;
    localparam logic [7:0] EXE_LUI_OP   = 8'b0101_1100;
    localparam logic [7:0] EXE_SLL_OP   = 8'b0111_1100;
    localparam logic [7:0] EXE_SLLV_OP  = 8'b0000_0100;
    localparam logic [7:0] EXE_SRL_OP   = 8'b0000_0010;
    localparam logic [7:0] EXE_SRLV_OP  = 8'b0000_0110;
    localparam logic [7:0] EXE_SRA_OP   = 8'b0000_0011;
    localparam logic [7:0] EXE_SRAV_OP  = 8'b0000_0111;
    localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
    localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
    localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
    localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
    localparam logic [7:0] EXE_SLT_OP   = 8'b0010_1010;
    localparam logic [7:0] EXE_SLTU_OP  = 8'b0010_1011;
    localparam logic [7:0] EXE_SLTI_OP  = 8'b0101_0111;
    localparam logic [7:0] EXE_SLTIU_OP = 8'b0101_1000;
    localparam logic [7:0] EXE_ADD_OP   = 8'b0010_0000;
    localparam logic [7:0] EXE_ADDU_OP  = 8'b0010_0001;
    localparam logic [7:0] EXE_SUB_OP   = 8'b0010_0010;
    localparam logic [7:0] EXE_SUBU_OP  = 8'b0010_0011;
    localparam logic [7:0] EXE_ADDI_OP  = 8'b0101_0101;
    localparam logic [7:0] EXE_ADDIU_OP = 8'b0101_0110;
    localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'd0,
        DIV_BY_ZERO = 2'd1,
        DIV_ON      = 2'd2,
        DIV_END     = 2'd3
    } div_state_e;

    div_state_e          state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [WorkW-1:0]    work_q, work_d;
    logic [RegBus-1:0]   divisor_q, divisor_d;
    logic                neg_quot_q, neg_quot_d;
    logic                neg_rem_q, neg_rem_d;

    logic                is_div_c;
    logic                div_busy_c;
    logic                hold_c;
    logic [RegBus:0]     step_diff_c;
    logic [WorkW-1:0]    step_c;
    logic [RegBus-1:0]   quot_c, rem_c;
    logic [RegBus-1:0]   abs1_c, abs2_c;

    logic [RegBus-1:0]   add_c, sub_c, logic_c, shift_c, arith_c, move_c;
    logic [63:0]         mul_s_c, mul_u_c;
    logic                ovf_c;
    logic [4:0]          sa_c;
    logic [3:0]          stall_unused;

    assign stall_unused = {stall[5:4], stall[2:1]} ^ {3'b000, stall[0]};

    assign is_div_c   = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);
    assign div_busy_c = is_div_c && (state_q != DIV_END);
    // A STOP we did not request ourselves comes from further down: freeze.
    assign hold_c     = stall[3] && !div_busy_c;

    // Arithmetic, compare and overflow
    assign add_c = reg1_i + reg2_i;
    assign sub_c = reg1_i - reg2_i;
    always_comb begin
        ovf_c = 1'b0;
        if (aluop_i == EXE_ADD_OP || aluop_i == EXE_ADDI_OP) begin
            ovf_c = (reg1_i[31] == reg2_i[31]) && (add_c[31] != reg1_i[31]);
        end else if (aluop_i == EXE_SUB_OP) begin
            ovf_c = (reg1_i[31] != reg2_i[31]) && (sub_c[31] != reg1_i[31]);
        end
    end

    // Products: signed for MUL/MULT, unsigned for MULTU
    assign mul_s_c = $signed({{32{reg1_i[31]}}, reg1_i}) * $signed({{32{reg2_i[31]}}, reg2_i});
    assign mul_u_c = {32'b0, reg1_i} * {32'b0, reg2_i};

    // Logic results; LUI arrives with {imm, 16'b0} already in reg2_i
    always_comb begin
        logic_c = '0;
        case (aluop_i)
            EXE_AND_OP, EXE_ANDI_OP: logic_c = reg1_i & reg2_i;
            EXE_OR_OP,  EXE_ORI_OP:  logic_c = reg1_i | reg2_i;
            EXE_XOR_OP, EXE_XORI_OP: logic_c = reg1_i ^ reg2_i;
            EXE_NOR_OP:              logic_c = ~(reg1_i | reg2_i);
            EXE_LUI_OP:              logic_c = reg2_i;
            default:                 logic_c = '0;
        endcase
    end

    // Shift results
    assign sa_c = reg1_i[4:0];
    always_comb begin
        shift_c = '0;
        case (aluop_i)
            EXE_SLL_OP, EXE_SLLV_OP: shift_c = reg2_i << sa_c;
            EXE_SRL_OP, EXE_SRLV_OP: shift_c = reg2_i >> sa_c;
            EXE_SRA_OP, EXE_SRAV_OP: shift_c = 32'($signed(reg2_i) >>> sa_c);
            default:                 shift_c = '0;
        endcase
    end

    // Arithmetic class results
    always_comb begin
        arith_c = '0;
        case (aluop_i)
            EXE_ADD_OP, EXE_ADDU_OP, EXE_ADDI_OP, EXE_ADDIU_OP: arith_c = add_c;
            EXE_SUB_OP, EXE_SUBU_OP:   arith_c = sub_c;
            EXE_SLT_OP, EXE_SLTI_OP:   arith_c = {31'b0, $signed(reg1_i) < $signed(reg2_i)};
            EXE_SLTU_OP, EXE_SLTIU_OP: arith_c = {31'b0, reg1_i < reg2_i};
            default:                   arith_c = '0;
        endcase
    end

    always_comb begin
        move_c = '0;
        case (aluop_i)
            EXE_MFHI_OP: move_c = hi_i;
            EXE_MFLO_OP: move_c = lo_i;
            default:     move_c = '0;
        endcase
    end

    // Divider datapath: one restoring shift-subtract step
    assign step_diff_c = {1'b0, work_q[63:32]} - {1'b0, divisor_q};
    assign step_c      = step_diff_c[RegBus] ? {work_q[63:0], 1'b0}
                                             : {step_diff_c[31:0], work_q[31:0], 1'b1};
    assign quot_c      = neg_quot_q ? -step_c[31:0]  : step_c[31:0];
    assign rem_c       = neg_rem_q  ? -step_c[64:33] : step_c[64:33];
    assign abs1_c      = (aluop_i == EXE_DIV_OP && reg1_i[31]) ? -reg1_i : reg1_i;
    assign abs2_c      = (aluop_i == EXE_DIV_OP && reg2_i[31]) ? -reg2_i : reg2_i;

    // Divider state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= DIV_FREE;
            cnt_q      <= '0;
            work_q     <= '0;
            divisor_q  <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            divisor_q  <= divisor_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
        end
    end

    // Divider next state
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        work_d     = work_q;
        divisor_d  = divisor_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        if (!hold_c) begin
            case (state_q)
                DIV_FREE: begin
                    if (is_div_c) begin
                        if (reg2_i == '0) begin
                            state_d = DIV_BY_ZERO;
                        end else begin
                            state_d    = DIV_ON;
                            cnt_d      = '0;
                            work_d     = {32'b0, abs1_c, 1'b0};
                            divisor_d  = abs2_c;
                            neg_quot_d = (aluop_i == EXE_DIV_OP) && (reg1_i[31] ^ reg2_i[31]);
                            neg_rem_d  = (aluop_i == EXE_DIV_OP) && reg1_i[31];
                        end
                    end
                end
                DIV_BY_ZERO: begin
                    state_d = DIV_END;
                    work_d  = '0;
                end
                DIV_ON: begin
                    if (!is_div_c) begin
                        state_d = DIV_FREE;
                        cnt_d   = '0;
                    end else if (cnt_q == CntW'(31)) begin
                        // Final step: store signed-corrected {rem, -, quot}
                        state_d = DIV_END;
                        cnt_d   = '0;
                        work_d  = {rem_c, 1'b0, quot_c};
                    end else begin
                        work_d = step_c;
                        cnt_d  = cnt_q + CntW'(1);
                    end
                end
                DIV_END: begin
                    state_d = DIV_FREE;
                end
                default: state_d = DIV_FREE;
            endcase
        end
    end

    // Stage outputs; everything forced to zero while reset is asserted
    always_comb begin
        wd_o     = '0;
        wreg_o   = 1'b0;
        wdata_o  = '0;
        whilo_o  = 1'b0;
        hi_o     = '0;
        lo_o     = '0;
        stallreq = 1'b0;
        if (rst) begin
            wd_o     = wd_i;
            wreg_o   = wreg_i && !ovf_c;
            stallreq = div_busy_c;
            case (alusel_i)
                EXE_RES_LOGIC:       wdata_o = logic_c;
                EXE_RES_SHIFT:       wdata_o = shift_c;
                EXE_RES_ARITHMETIC:  wdata_o = arith_c;
                EXE_RES_MOVE:        wdata_o = move_c;
                EXE_RES_JUMP_BRANCH: wdata_o = link_address_i;
                EXE_RES_MUL:         wdata_o = mul_s_c[31:0];
                default:             wdata_o = '0;
            endcase
            case (aluop_i)
                EXE_MTHI_OP: begin
                    whilo_o = 1'b1; hi_o = reg1_i; lo_o = lo_i;
                end
                EXE_MTLO_OP: begin
                    whilo_o = 1'b1; hi_o = hi_i; lo_o = reg1_i;
                end
                EXE_MULT_OP: begin
                    whilo_o = 1'b1; {hi_o, lo_o} = mul_s_c;
                end
                EXE_MULTU_OP: begin
                    whilo_o = 1'b1; {hi_o, lo_o} = mul_u_c;
                end
                EXE_DIV_OP, EXE_DIVU_OP: begin
                    if (state_q == DIV_END) begin
                        whilo_o = 1'b1;
                        hi_o    = work_q[64:33];
                        lo_o    = work_q[31:0];
                    end
                end
                default: whilo_o = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_ex.sv
// Self-checking bench for the execute stage: table of single-cycle vectors
// plus hand-written divide, flush, downstream-stall and reset sequences.
module tb_ex;

    localparam logic [2:0] S_NOP = 3'b000, S_LOG = 3'b001, S_SHF = 3'b010,
                           S_MOV = 3'b011, S_ARI = 3'b100, S_MUL = 3'b101,
                           S_JB  = 3'b110, S_BAD = 3'b111;

    localparam logic [7:0] OP_NOP  = 8'h00,        OP_AND  = 8'b0010_0100,
                           OP_OR   = 8'b0010_0101, OP_XOR  = 8'b0010_0110,
                           OP_NOR  = 8'b0010_0111, OP_SLL  = 8'b0111_1100,
                           OP_SRL  = 8'b0000_0010, OP_SRA  = 8'b0000_0011,
                           OP_MFHI = 8'b0001_0000, OP_MTHI = 8'b0001_0001,
                           OP_MFLO = 8'b0001_0010, OP_MTLO = 8'b0001_0011,
                           OP_SLT  = 8'b0010_1010, OP_SLTU = 8'b0010_1011,
                           OP_ADD  = 8'b0010_0000, OP_ADDU = 8'b0010_0001,
                           OP_SUB  = 8'b0010_0010, OP_SUBU = 8'b0010_0011,
                           OP_ADDI = 8'b0101_0101, OP_MULT = 8'b0001_1000,
                           OP_MULTU= 8'b0001_1001, OP_MUL  = 8'b1010_1001,
                           OP_DIV  = 8'b0001_1010, OP_DIVU = 8'b0001_1011,
                           OP_JAL  = 8'b0101_0000;

    localparam logic [31:0] HI_IN = 32'h1111_2222, LO_IN = 32'h3333_4444,
                            LINK  = 32'h0040_0010;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] reg1, reg2;
    logic [4:0]  wd_in;
    logic        wreg_in;
    logic [5:0]  ds_stall;
    logic [5:0]  stall;
    logic [4:0]  wd_out;
    logic        wreg_out, whilo, stallreq;
    logic [31:0] wdata, hi_out, lo_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Stall controller: EX request stalls IF..EX; otherwise downstream stall
    assign stall = stallreq ? 6'b001111 : ds_stall;

    ex dut (
        .clk(clk), .rst(rst), .aluop_i(aluop), .alusel_i(alusel),
        .reg1_i(reg1), .reg2_i(reg2), .wd_i(wd_in), .wreg_i(wreg_in),
        .link_address_i(LINK), .hi_i(HI_IN), .lo_i(LO_IN), .stall(stall),
        .wd_o(wd_out), .wreg_o(wreg_out), .wdata_o(wdata), .whilo_o(whilo),
        .hi_o(hi_out), .lo_o(lo_out), .stallreq(stallreq)
    );

    typedef struct {
        logic [7:0]  op;
        logic [2:0]  sel;
        logic [31:0] r1, r2;
        logic        wr;
        logic [31:0] e_wdata;
        logic        e_wreg;
        logic        e_whilo;
        logic [31:0] e_hi, e_lo;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [7:0] op, logic [2:0] sel, logic [31:0] r1, r2,
                                logic wr, logic [31:0] wdv, logic ewr, logic ewh,
                                logic [31:0] ehi, elo);
        vec_t v;
        v.op = op; v.sel = sel; v.r1 = r1; v.r2 = r2; v.wr = wr;
        v.e_wdata = wdv; v.e_wreg = ewr; v.e_whilo = ewh; v.e_hi = ehi; v.e_lo = elo;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] op, input logic [2:0] sel,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] wd, input logic wr);
        aluop = op; alusel = sel; reg1 = a; reg2 = b; wd_in = wd; wreg_in = wr;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    // Applies a divide at the current negedge and follows it to the END cycle
    task automatic run_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int exp_req, input logic [31:0] exp_q,
                           input logic [31:0] exp_r, input string nm);
        int  req_cnt;
        bit  done;
        req_cnt = 0;
        done    = 1'b0;
        drive(op, S_NOP, a, b, 5'd0, 1'b0);
        #1;
        for (int c = 0; c < 60 && !done; c++) begin
            if (stallreq) begin
                req_cnt++;
                next_cycle();
            end else begin
                done = 1'b1;
            end
        end
        chk({nm, " finished"}, 64'(done), 64'd1);
        chk({nm, " stallreq cycles"}, 64'(req_cnt), 64'(exp_req));
        chk({nm, " whilo"}, 64'(whilo), 64'd1);
        chk({nm, " quotient lo"}, 64'(lo_out), 64'(exp_q));
        chk({nm, " remainder hi"}, 64'(hi_out), 64'(exp_r));
    endtask

    initial begin
        rst = 1'b0;
        ds_stall = 6'b0;
        drive(OP_ADD, S_ARI, 32'h7FFF_FFFF, 32'h1, 5'd7, 1'b1);
        next_cycle();
        next_cycle();
        // Outputs all zero under reset even with a live instruction present
        chk("reset wd_o", 64'(wd_out), 64'd0);
        chk("reset wreg_o", 64'(wreg_out), 64'd0);
        chk("reset wdata_o", 64'(wdata), 64'd0);
        chk("reset whilo/stallreq", 64'({whilo, stallreq}), 64'd0);

        vecs.push_back(mk(OP_ADD,  S_ARI, 32'h7FFF_FFFF, 32'h1, 1, 32'h8000_0000, 0, 0, 0, 0));
        vecs.push_back(mk(OP_ADDU, S_ARI, 32'h7FFF_FFFF, 32'h1, 1, 32'h8000_0000, 1, 0, 0, 0));
        vecs.push_back(mk(OP_ADDI, S_ARI, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h7FFF_FFFF, 0, 0, 0, 0));
        vecs.push_back(mk(OP_SUB,  S_ARI, 32'h8000_0000, 32'h1, 1, 32'h7FFF_FFFF, 0, 0, 0, 0));
        vecs.push_back(mk(OP_SUB,  S_ARI, 32'd5, 32'd7, 1, 32'hFFFF_FFFE, 1, 0, 0, 0));
        vecs.push_back(mk(OP_SUBU, S_ARI, 32'd5, 32'd7, 1, 32'hFFFF_FFFE, 1, 0, 0, 0));
        vecs.push_back(mk(OP_SRA,  S_SHF, 32'd4, 32'h8000_0000, 1, 32'hF800_0000, 1, 0, 0, 0));
        vecs.push_back(mk(OP_SRL,  S_SHF, 32'd4, 32'h8000_0000, 1, 32'h0800_0000, 1, 0, 0, 0));
        vecs.push_back(mk(OP_SLL,  S_SHF, 32'd31, 32'h1, 1, 32'h8000_0000, 1, 0, 0, 0));
        vecs.push_back(mk(OP_SLTU, S_ARI, 32'hFFFF_FFFF, 32'h1, 1, 32'h0, 1, 0, 0, 0));
        vecs.push_back(mk(OP_SLT,  S_ARI, 32'hFFFF_FFFF, 32'h1, 1, 32'h1, 1, 0, 0, 0));
        vecs.push_back(mk(OP_AND,  S_LOG, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1, 32'h00F0_00F0, 1, 0, 0, 0));
        vecs.push_back(mk(OP_OR,   S_LOG, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1, 32'hFFF0_FFF0, 1, 0, 0, 0));
        vecs.push_back(mk(OP_XOR,  S_LOG, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1, 32'hFF00_FF00, 1, 0, 0, 0));
        vecs.push_back(mk(OP_NOR,  S_LOG, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1, 32'h000F_000F, 1, 0, 0, 0));
        vecs.push_back(mk(OP_MFHI, S_MOV, 32'h0, 32'h0, 1, HI_IN, 1, 0, 0, 0));
        vecs.push_back(mk(OP_MFLO, S_MOV, 32'h0, 32'h0, 1, LO_IN, 1, 0, 0, 0));
        vecs.push_back(mk(OP_JAL,  S_JB,  32'h0, 32'h0, 1, LINK, 1, 0, 0, 0));
        vecs.push_back(mk(OP_MUL,  S_MUL, 32'hFFFF_FFFE, 32'd3, 1, 32'hFFFF_FFFA, 1, 0, 0, 0));
        vecs.push_back(mk(OP_MULT, S_NOP, 32'hFFFF_FFFE, 32'd3, 0, 32'h0, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFA));
        vecs.push_back(mk(OP_MULTU,S_NOP, 32'hFFFF_FFFE, 32'd3, 0, 32'h0, 0, 1, 32'h2, 32'hFFFF_FFFA));
        vecs.push_back(mk(OP_MTHI, S_NOP, 32'hDEAD_BEEF, 32'h0, 0, 32'h0, 0, 1, 32'hDEAD_BEEF, LO_IN));
        vecs.push_back(mk(OP_MTLO, S_NOP, 32'hCAFE_F00D, 32'h0, 0, 32'h0, 0, 1, HI_IN, 32'hCAFE_F00D));
        vecs.push_back(mk(OP_ADD,  S_BAD, 32'd1, 32'd2, 1, 32'h0, 1, 0, 0, 0));

        rst = 1'b1;
        foreach (vecs[i]) begin
            next_cycle();
            drive(vecs[i].op, vecs[i].sel, vecs[i].r1, vecs[i].r2, 5'(i + 1), vecs[i].wr);
            #1;
            chk($sformatf("vec%0d wdata_o", i), 64'(wdata), 64'(vecs[i].e_wdata));
            chk($sformatf("vec%0d wreg_o", i), 64'(wreg_out), 64'(vecs[i].e_wreg));
            chk($sformatf("vec%0d wd_o", i), 64'(wd_out), 64'(i + 1));
            chk($sformatf("vec%0d whilo_o", i), 64'(whilo), 64'(vecs[i].e_whilo));
            chk($sformatf("vec%0d hi_o", i), 64'(hi_out), 64'(vecs[i].e_hi));
            chk($sformatf("vec%0d lo_o", i), 64'(lo_out), 64'(vecs[i].e_lo));
            chk($sformatf("vec%0d stallreq", i), 64'(stallreq), 64'd0);
        end

        // Signed divide -7 / 2: quotient -3, remainder -1
        next_cycle();
        run_div(OP_DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "div -7/2");
        // Cycle 35: back in FREE, same DIV still present starts a new divide
        next_cycle();
        chk("div restart stallreq", 64'(stallreq), 64'd1);
        chk("div restart whilo", 64'(whilo), 64'd0);
        // Op removed mid-divide: flush, no HI/LO write
        next_cycle();
        drive(OP_NOP, S_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
        #1;
        chk("flush stallreq", 64'(stallreq), 64'd0);
        chk("flush whilo", 64'(whilo), 64'd0);

        // Divide by zero right after the flush: must start from FREE
        next_cycle();
        run_div(OP_DIVU, 32'd10, 32'd0, 2, 32'd0, 32'd0, "divu 10/0");

        // Another by-zero divide, held in END by a downstream stall
        next_cycle();
        run_div(OP_DIVU, 32'd10, 32'd0, 2, 32'd0, 32'd0, "divu 10/0 held");
        ds_stall = 6'b011111;
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            chk($sformatf("end hold%0d whilo", k), 64'(whilo), 64'd1);
            chk($sformatf("end hold%0d stallreq", k), 64'(stallreq), 64'd0);
        end
        ds_stall = 6'b0;
        next_cycle();
        chk("end released to free", 64'(stallreq), 64'd1);
        drive(OP_NOP, S_NOP, 32'h0, 32'h0, 5'd0, 1'b0);

        // Reset during a divide, then restart with the same op
        next_cycle();
        drive(OP_DIVU, S_NOP, 32'd100, 32'd7, 5'd9, 1'b1);
        for (int k = 0; k < 10; k++) next_cycle();
        rst = 1'b0;
        #1;
        chk("midreset stallreq", 64'(stallreq), 64'd0);
        chk("midreset wd/wreg", 64'({wd_out, wreg_out}), 64'd0);
        chk("midreset whilo/hi/lo", 64'({whilo, hi_out, lo_out}), 64'd0);
        next_cycle();
        next_cycle();
        chk("held reset stallreq", 64'(stallreq), 64'd0);
        rst = 1'b1;
        run_div(OP_DIVU, 32'd100, 32'd7, 33, 32'd14, 32'd2, "divu 100/7 after reset");

        next_cycle();
        drive(OP_NOP, S_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
        #1;
        chk("idle whilo", 64'(whilo), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
